// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch
// ----------------------------------------------------------------------------
// Instruction fetch stage feeding the 8-bit instruction register. It owns the
// program counter, reads program memory over a req/ack handshake and drives
// the IR load bus (data plus a one-cycle write enable). It also supports
// downstream stall, branch redirect and halt.
//
// Ports
//   IF_clk, IF_rst_n    clock (rising edge) and asynchronous active-low reset
//   IF_stall            downstream not ready: hold delivery, issue no request
//   IF_halt             level request to stop fetching after current fetch
//   IF_branch_en/addr   one-cycle redirect strobe and its target
//   IF_mem_req/addr     read request (held until ack) and stable address
//   IF_mem_rdata/ack    read data, valid in the ack cycle
//   IF_ir_data/we       instruction and one-cycle IR write enable
//   IF_pc               address of the next instruction to request
//   IF_halted           high while in HALT
//   IF_fault            sticky ack-timeout flag
//
// Build option
//   IF_TIMEOUT_EN  when defined, a WAIT that lasts TIMEOUT cycles without ack
//                  sets IF_fault, drops the request and parks in HALT until
//                  reset. When undefined, WAIT lasts indefinitely and
//                  IF_fault is tied low.
// ============================================================================
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 32'd8,
    parameter int unsigned       DATA_W   = 32'd8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int unsigned       TIMEOUT  = 32'd15
) (
    input  logic              IF_clk,
    input  logic              IF_rst_n,
    input  logic              IF_stall,
    input  logic              IF_halt,
    input  logic              IF_branch_en,
    input  logic [ADDR_W-1:0] IF_branch_addr,
    output logic              IF_mem_req,
    output logic [ADDR_W-1:0] IF_mem_addr,
    input  logic [DATA_W-1:0] IF_mem_rdata,
    input  logic              IF_mem_ack,
    output logic [DATA_W-1:0] IF_ir_data,
    output logic              IF_ir_we,
    output logic [ADDR_W-1:0] IF_pc,
    output logic              IF_halted,
    output logic              IF_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic              req_q,     req_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic              ir_we_q,   ir_we_d;
    logic              halted_q,  halted_d;
    logic [DATA_W-1:0] hold_q,    hold_d;
    // Set when a branch lands while a read is outstanding: the returning
    // data belongs to the abandoned path and must not reach the IR.
    logic              discard_q, discard_d;
    logic              fault_s;

`ifdef IF_TIMEOUT_EN
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    assign fault_s = fault_q;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT == 32'd0);
    assign fault_s          = 1'b0;
`endif

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        ir_data_d = ir_data_q;
        ir_we_d   = 1'b0;
        halted_d  = halted_q;
        hold_d    = hold_q;
        discard_d = discard_q;
`ifdef IF_TIMEOUT_EN
        cnt_d     = CNT_ZERO;
        fault_d   = fault_q;
`endif
        case (state_q)
            S_REQ: begin
                req_d = 1'b0;
                if (IF_branch_en) begin
                    pc_d = IF_branch_addr;
                end else begin
                    pc_d = pc_q;
                end
                if (IF_halt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (!IF_stall) begin
                    // A redirect arriving with the issue goes straight out.
                    req_d     = 1'b1;
                    addr_d    = IF_branch_en ? IF_branch_addr : pc_q;
                    discard_d = 1'b0;
                    state_d   = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_WAIT: begin
                if (IF_mem_ack) begin
                    req_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = S_REQ;
                    if (IF_branch_en) begin
                        // Branch beats the increment; data dropped.
                        pc_d = IF_branch_addr;
                    end else if (discard_q) begin
                        // PC already redirected earlier; data dropped.
                        pc_d = pc_q;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                        if (!IF_stall) begin
                            ir_data_d = IF_mem_rdata;
                            ir_we_d   = 1'b1;
                        end else begin
                            hold_d  = IF_mem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    if (IF_branch_en) begin
                        pc_d      = IF_branch_addr;
                        discard_d = 1'b1;
                    end else begin
                        pc_d = pc_q;
                    end
`ifdef IF_TIMEOUT_EN
                    if (cnt_q == CNT_LAST) begin
                        fault_d  = 1'b1;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`endif
                end
            end

            S_HOLD: begin
                if (IF_branch_en) begin
                    pc_d    = IF_branch_addr;
                    state_d = S_REQ;
                end else if (!IF_stall) begin
                    ir_data_d = hold_q;
                    ir_we_d   = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end

            S_HALT: begin
                req_d    = 1'b0;
                halted_d = 1'b1;
                if (IF_branch_en) begin
                    pc_d = IF_branch_addr;
                end else begin
                    pc_d = pc_q;
                end
                // A timeout fault pins the stage here until reset.
                if (!IF_halt && !fault_s) begin
                    halted_d = 1'b0;
                    state_d  = S_REQ;
                end else begin
                    state_d = S_HALT;
                end
            end

            default: begin
                state_d   = S_REQ;
                req_d     = 1'b0;
                halted_d  = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge IF_clk or negedge IF_rst_n) begin
        if (!IF_rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            ir_data_q <= {DATA_W{1'b0}};
            ir_we_q   <= 1'b0;
            halted_q  <= 1'b0;
            hold_q    <= {DATA_W{1'b0}};
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            ir_data_q <= ir_data_d;
            ir_we_q   <= ir_we_d;
            halted_q  <= halted_d;
            hold_q    <= hold_d;
            discard_q <= discard_d;
        end
    end

`ifdef IF_TIMEOUT_EN
    // Ack-timeout counter and sticky fault flag.
    always_ff @(posedge IF_clk or negedge IF_rst_n) begin
        if (!IF_rst_n) begin
            cnt_q   <= CNT_ZERO;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
`endif

    assign IF_mem_req  = req_q;
    assign IF_mem_addr = addr_q;
    assign IF_ir_data  = ir_data_q;
    assign IF_ir_we    = ir_we_q;
    assign IF_pc       = pc_q;
    assign IF_halted   = halted_q;
    assign IF_fault    = fault_s;

endmodule
